wb_regfile: RTL and testbench

//   Write-back sink of the five-stage pipeline: consumes the registered MEM/WB outputs
//   (GPR write and HI/LO write) and commits them into the 32-entry general-purpose

---
 rtl/wb_regfile.sv | 98 +++++++++
 tb/tb_wb_regfile.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back sink: 32-entry GPR file, HI/LO pair and commit counter.
// Define WB_REGFILE_BYPASS_EN for same-cycle read-during-write bypass.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_wreg,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [CNT_W-1:0]  commit_cnt
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_gpr [NREG];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [CNT_W-1:0]  r_cnt;

    logic w_gpr_we;
    logic w_commit;

    assign w_gpr_we = wb_wreg && (wb_wd != '0);
    // HI/LO and GPR commits in the same cycle count once
    assign w_commit = w_gpr_we || wb_whilo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_gpr[i] <= '0;
            end
            r_hi  <= '0;
            r_lo  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_gpr_we) begin
                r_gpr[wb_wd] <= wb_wdata;
            end
            if (wb_whilo) begin
                r_hi <= wb_hi;
                r_lo <= wb_lo;
            end
            if (w_commit) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        hi_o   = '0;
        lo_o   = '0;
        if (rst) begin
            if (re1 && (raddr1 != '0)) begin
                rdata1 = r_gpr[raddr1];
`ifdef WB_REGFILE_BYPASS_EN
                if (w_gpr_we && (wb_wd == raddr1)) begin
                    rdata1 = wb_wdata;
                end
`endif
            end
            if (re2 && (raddr2 != '0)) begin
                rdata2 = r_gpr[raddr2];
`ifdef WB_REGFILE_BYPASS_EN
                if (w_gpr_we && (wb_wd == raddr2)) begin
                    rdata2 = wb_wdata;
                end
`endif
            end
            hi_o = r_hi;
            lo_o = r_lo;
`ifdef WB_REGFILE_BYPASS_EN
            if (wb_whilo) begin
                hi_o = wb_hi;
                lo_o = wb_lo;
            end
`endif
        end
    end

    assign commit_cnt = r_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed table, randomized model checks,
// mid-operation reset and 4-bit commit counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] commit_cnt;

    logic [31:0] s_rdata1, s_rdata2, s_hi, s_lo;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o), .commit_cnt(commit_cnt)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .re1(re1), .raddr1(raddr1), .rdata1(s_rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(s_rdata2),
        .hi_o(s_hi), .lo_o(s_lo), .commit_cnt(cnt4)
    );

    // Reference state
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo, m_cnt;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] rd1_nb, rd1_by, rd2_nb, rd2_by, hi_nb, hi_by, lo_nb, lo_by;
        logic [31:0] cnt;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
        if (!rst || !re || a == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (wb_wreg && wb_wd == a) return wb_wdata;
`endif
        return m_gpr[a];
    endfunction

    function automatic logic [31:0] m_hilo(input logic sel_hi);
        if (!rst) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (wb_whilo) return sel_hi ? wb_hi : wb_lo;
`endif
        return sel_hi ? m_hi : m_lo;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi  = 32'h0;
        m_lo  = 32'h0;
        m_cnt = 32'h0;
    endtask

    task automatic model_commit();
        if (!rst) return;
        if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] = wb_wdata;
        if (wb_whilo) begin
            m_hi = wb_hi;
            m_lo = wb_lo;
        end
        if ((wb_wreg && wb_wd != 5'd0) || wb_whilo) m_cnt = m_cnt + 32'd1;
    endtask

    task automatic set_idle();
        wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'h0;
        wb_whilo = 1'b0; wb_hi = 32'h0; wb_lo = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    endtask

    task automatic check_model(input string tag);
        check({tag, " rdata1"}, rdata1, m_read(re1, raddr1));
        check({tag, " rdata2"}, rdata2, m_read(re2, raddr2));
        check({tag, " hi_o"}, hi_o, m_hilo(1'b1));
        check({tag, " lo_o"}, lo_o, m_hilo(1'b0));
        check({tag, " commit_cnt"}, commit_cnt, m_cnt);
        check({tag, " cnt4"}, {28'h0, cnt4}, {28'h0, m_cnt[3:0]});
    endtask

    task automatic cycle_model(input string tag);
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rdata1"}, rdata1, 32'h0);
        check({tag, " rdata2"}, rdata2, 32'h0);
        check({tag, " hi_o"}, hi_o, 32'h0);
        check({tag, " lo_o"}, lo_o, 32'h0);
        check({tag, " commit_cnt"}, commit_cnt, 32'h0);
        check({tag, " cnt4"}, {28'h0, cnt4}, 32'h0);
    endtask

    initial begin
        vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0,
                  32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0};
        vt[1] = '{1'b1, 5'd0, 32'h00001234, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd0,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'd1};
        vt[2] = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd7,
                  32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 32'h0, 32'd1};
        vt[3] = '{1'b1, 5'd3, 32'hCAFE0003, 1'b1, 32'h11, 32'h22, 1'b1, 5'd7, 1'b1, 5'd3,
                  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'hCAFE0003, 32'h0, 32'h11,
                  32'h0, 32'h22, 32'd2};
        vt[4] = '{1'b0, 5'd3, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd3,
                  32'hCAFE0003, 32'hCAFE0003, 32'h0, 32'h0, 32'h11, 32'h11, 32'h22,
                  32'h22, 32'd3};
        vt[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 32'h33, 32'h44, 1'b1, 5'd5, 1'b1, 5'd5,
                  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h11,
                  32'h33, 32'h22, 32'h44, 32'd3};
        vt[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd7,
                  32'h0, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h33, 32'h33, 32'h44,
                  32'h44, 32'd4};

        set_idle();
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd31;
        #1;
        check_all_zero("post-reset");
        @(posedge clk);
        #1;

        // Directed table
        foreach (vt[k]) begin
            wb_wreg = vt[k].wreg; wb_wd = vt[k].wd; wb_wdata = vt[k].wdata;
            wb_whilo = vt[k].whilo; wb_hi = vt[k].hi; wb_lo = vt[k].lo;
            re1 = vt[k].re1; raddr1 = vt[k].ra1; re2 = vt[k].re2; raddr2 = vt[k].ra2;
            @(negedge clk);
`ifdef WB_REGFILE_BYPASS_EN
            check($sformatf("tbl%0d rdata1", k), rdata1, vt[k].rd1_by);
            check($sformatf("tbl%0d rdata2", k), rdata2, vt[k].rd2_by);
            check($sformatf("tbl%0d hi_o", k), hi_o, vt[k].hi_by);
            check($sformatf("tbl%0d lo_o", k), lo_o, vt[k].lo_by);
`else
            check($sformatf("tbl%0d rdata1", k), rdata1, vt[k].rd1_nb);
            check($sformatf("tbl%0d rdata2", k), rdata2, vt[k].rd2_nb);
            check($sformatf("tbl%0d hi_o", k), hi_o, vt[k].hi_nb);
            check($sformatf("tbl%0d lo_o", k), lo_o, vt[k].lo_nb);
`endif
            check($sformatf("tbl%0d commit_cnt", k), commit_cnt, vt[k].cnt);
            check($sformatf("tbl%0d cnt4", k), {28'h0, cnt4}, vt[k].cnt);
            @(posedge clk);
            model_commit();
            #1;
        end

        // Randomized traffic, addresses biased low to force collisions
        for (int i = 0; i < 300; i++) begin
            wb_wreg  = ($urandom_range(0, 1) == 1);
            wb_wd    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wb_wdata = $urandom;
            wb_whilo = ($urandom_range(0, 3) == 0);
            wb_hi    = $urandom;
            wb_lo    = $urandom;
            re1      = ($urandom_range(0, 3) != 0);
            raddr1   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            re2      = ($urandom_range(0, 3) != 0);
            raddr2   = ($urandom_range(0, 1) == 0) ? raddr1 : 5'($urandom_range(0, 7));
            cycle_model("rand");
        end

        // Asynchronous reset mid-write with nonzero state
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'h99999999;
        wb_whilo = 1'b1; wb_hi = 32'h77; wb_lo = 32'h88;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd5;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("async-rst");
        @(posedge clk);
        #1;
        check_all_zero("held-rst");
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd5;
        #1;
        check_all_zero("after-rst");
        @(posedge clk);
        #1;

        // 16 commits: 4-bit counter wraps 15 -> 0
        for (int i = 0; i < 16; i++) begin
            set_idle();
            wb_whilo = 1'b1; wb_hi = 32'(i); wb_lo = 32'(i + 100);
            cycle_model("wrap");
        end
        set_idle();
        @(negedge clk);
        check("wrap cnt4", {28'h0, cnt4}, 32'h0);
        check("wrap commit_cnt", commit_cnt, 32'd16);
        check("wrap hi_o", hi_o, 32'd15);
        check("wrap lo_o", lo_o, 32'd115);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
